// File: rtl/mem_window_reader.sv
// mem_window_reader
//   Walks a 2-D byte window in a 32-bit-word, byte-addressable scratch memory.
//   The window is rowCount rows of rowLen bytes, with rows rowStride bytes
//   apart, starting at baseAddr. One byte is read per cycle and the bytes are
//   delivered in order on a valid/ready stream through a small output FIFO.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   start                launch request, only looked at while idle
//   baseAddr, rowLen,    window geometry, latched when start is accepted
//   rowCount, rowStride
//   busy                 high while a window is in progress (not idle)
//   done                 one-cycle pulse in the first idle cycle after a window
//   memREn, memAddr      memory read port (byte address)
//   memDataIn            combinational read data for the current memAddr
//   outValid, outData    output stream head: valid flag and byte
//   outRowEnd, outLast   head byte closes its row / closes the window
//   outReady             consumer accepts the head byte
module mem_window_reader #(
   parameter int LEN_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      baseAddr,
   input  logic [LEN_W-1:0] rowLen,
   input  logic [LEN_W-1:0] rowCount,
   input  logic [31:0]      rowStride,
   output logic             busy,
   output logic             done,
   output logic             memREn,
   output logic [31:0]      memAddr,
   input  logic [7:0]       memDataIn,
   output logic             outValid,
   output logic [7:0]       outData,
   output logic             outRowEnd,
   output logic             outLast,
   input  logic             outReady
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] rows_q, rows_d;
   logic [LEN_W-1:0] col_q, col_d;
   logic [LEN_W-1:0] row_q, row_d;
   logic [31:0]      stride_q, stride_d;
   logic [31:0]      row_base_q, row_base_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             done_q, done_d;

   // FIFO entry layout: {data[7:0], row_end, last}
   logic [9:0]       fifo_q [FIFO_DEPTH];
   logic [9:0]       fifo_d [FIFO_DEPTH];
   logic [9:0]       head;

   logic             push;
   logic             pop;
   logic             row_end;
   logic             win_last;
   logic             accept;
   logic             empty_win;

   assign accept    = (state_q == IDLE) && start;
   assign empty_win = (rowLen == '0) || (rowCount == '0);
   assign row_end   = (col_q == len_q - 1'b1);
   assign win_last  = row_end && (row_q == rows_q - 1'b1);
   assign push      = memREn;
   assign pop       = outValid && outReady;

   // Address comes straight from registers so outReady never reaches memAddr.
   assign memAddr   = row_base_q + 32'(col_q);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = empty_win ? DRAIN : FETCH;
            end
         end
         FETCH: begin
            if (push && win_last) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Leave once the FIFO is empty after this edge.
            if ((count_q == '0) || ((count_q == ONE_C) && pop)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      done_d = (state_q == DRAIN) && (state_d == IDLE);
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy   = (state_q != IDLE);
      done   = done_q;
      // Fetch gating looks only at FIFO occupancy, never at outReady.
      memREn = (state_q == FETCH) && (count_q < DEPTH_C);
   end

   // ---------------- window walker and FIFO bookkeeping ----------------
   always_comb begin
      len_d      = len_q;
      rows_d     = rows_q;
      stride_d   = stride_q;
      row_base_d = row_base_q;
      col_d      = col_q;
      row_d      = row_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      if (accept) begin
         len_d      = rowLen;
         rows_d     = rowCount;
         stride_d   = rowStride;
         row_base_d = baseAddr;
         col_d      = '0;
         row_d      = '0;
      end else if (push) begin
         if (row_end) begin
            col_d      = '0;
            row_d      = row_q + 1'b1;
            row_base_d = row_base_q + stride_q;
         end else begin
            col_d = col_q + 1'b1;
         end
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q      <= '0;
         rows_q     <= '0;
         stride_q   <= '0;
         row_base_q <= '0;
         col_q      <= '0;
         row_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         len_q      <= len_d;
         rows_q     <= rows_d;
         stride_q   <= stride_d;
         row_base_q <= row_base_d;
         col_q      <= col_d;
         row_q      <= row_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // ---------------- FIFO storage (data only, no reset) ----------------
   always_comb begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         fifo_d[i] = fifo_q[i];
      end
      if (push) begin
         fifo_d[wr_ptr_q] = {memDataIn, row_end, win_last};
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         fifo_q[i] <= fifo_d[i];
      end
   end

   // ---------------- output stream ----------------
   // Head fields are forced to zero while empty so stale entries never show.
   always_comb begin
      outValid  = (count_q != '0);
      head      = fifo_q[rd_ptr_q];
      outData   = outValid ? head[9:2] : 8'h00;
      outRowEnd = outValid && head[1];
      outLast   = outValid && head[0];
   end

endmodule

// File: tb/tb_mem_window_reader.sv
module tb_mem_window_reader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] baseAddr;
   logic [15:0] rowLen;
   logic [15:0] rowCount;
   logic [31:0] rowStride;
   logic        busy;
   logic        done;
   logic        memREn;
   logic [31:0] memAddr;
   logic [7:0]  memDataIn;
   logic        outValid;
   logic [7:0]  outData;
   logic        outRowEnd;
   logic        outLast;
   logic        outReady;

   mem_window_reader #(.LEN_W(16), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .baseAddr  (baseAddr),
      .rowLen    (rowLen),
      .rowCount  (rowCount),
      .rowStride (rowStride),
      .busy      (busy),
      .done      (done),
      .memREn    (memREn),
      .memAddr   (memAddr),
      .memDataIn (memDataIn),
      .outValid  (outValid),
      .outData   (outData),
      .outRowEnd (outRowEnd),
      .outLast   (outLast),
      .outReady  (outReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: fixed bytes at 0x10..0x13, a scrambled address hash elsewhere.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [7:0] r;
      case (a)
         32'h10:  r = 8'hAA;
         32'h11:  r = 8'hBB;
         32'h12:  r = 8'hCC;
         32'h13:  r = 8'hDD;
         default: r = (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
      endcase
      return r;
   endfunction

   assign memDataIn = mem_byte(memAddr);

   typedef struct packed {
      logic [7:0] d;
      logic       re;
      logic       last;
   } ent_t;

   ent_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   rd_cnt = 0;
   int   pop_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted output byte is popped from the scoreboard and compared.
   always @(negedge clk) begin
      if (rst_n) begin
         if (memREn) rd_cnt++;
         if (outValid && outReady) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_byte: got data 0x%0h with nothing expected at %0t",
                        outData, $time);
            end else begin
               ent_t e;
               e = exp_q.pop_front();
               chk("stream_entry", {22'd0, outData, outRowEnd, outLast}, {22'd0, e});
            end
         end
      end
   end

   // Issue a window: reference sequence is the plain row/column walk of the window.
   task automatic start_win(input logic [31:0] base, input logic [15:0] len,
                            input logic [15:0] cnt, input logic [31:0] stride);
      logic [31:0] addr;
      if (len != 0 && cnt != 0) begin
         for (int r = 0; r < int'(cnt); r++) begin
            for (int c = 0; c < int'(len); c++) begin
               addr = base + 32'(r) * stride + 32'(c);
               exp_q.push_back({mem_byte(addr), c == int'(len) - 1,
                                (c == int'(len) - 1) && (r == int'(cnt) - 1)});
            end
         end
      end
      baseAddr  = base;
      rowLen    = len;
      rowCount  = cnt;
      rowStride = stride;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input bit rnd);
      int n = 0;
      while (busy && n < budget) begin
         if (rnd) outReady = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      if (busy) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout: busy still 1 after %0d cycles, required 0", budget);
      end
      outReady = 1'b1;
   endtask

   initial begin
      logic [15:0] l, c;
      rst_n     = 1'b1;
      start     = 1'b0;
      baseAddr  = '0;
      rowLen    = '0;
      rowCount  = '0;
      rowStride = '0;
      outReady  = 1'b1;
      #1 rst_n  = 1'b0;
      #20;
      chk("rst_busy",     32'(busy),     0);
      chk("rst_done",     32'(done),     0);
      chk("rst_memREn",   32'(memREn),   0);
      chk("rst_memAddr",  memAddr,       0);
      chk("rst_outValid", 32'(outValid), 0);
      chk("rst_outData",  32'(outData),  0);
      chk("rst_flags",    {30'd0, outRowEnd, outLast}, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // 1x4 at 0x10 with cycle-exact timing
      start_win(32'h10, 16'd4, 16'd1, 32'd0);
      chk("t1_c1_memREn",   32'(memREn),   1);
      chk("t1_c1_memAddr",  memAddr,       32'h10);
      chk("t1_c1_busy",     32'(busy),     1);
      chk("t1_c1_outValid", 32'(outValid), 0);
      tick();
      chk("t1_c2_outValid", 32'(outValid), 1);
      chk("t1_c2_outData",  32'(outData),  32'hAA);
      chk("t1_c2_memAddr",  memAddr,       32'h11);
      tick();
      chk("t1_c3_outData",  32'(outData),  32'hBB);
      tick();
      chk("t1_c4_outData",  32'(outData),  32'hCC);
      chk("t1_c4_memAddr",  memAddr,       32'h13);
      chk("t1_c4_outLast",  32'(outLast),  0);
      tick();
      chk("t1_c5_outData",  32'(outData),  32'hDD);
      chk("t1_c5_flags",    {30'd0, outRowEnd, outLast}, 3);
      chk("t1_c5_busy",     32'(busy),     1);
      chk("t1_c5_done",     32'(done),     0);
      tick();
      chk("t1_c6_done",     32'(done),     1);
      chk("t1_c6_busy",     32'(busy),     0);
      chk("t1_c6_outValid", 32'(outValid), 0);
      tick();
      chk("t1_c7_done",     32'(done),     0);

      // 2-D window
      start_win(32'h100, 16'd3, 16'd2, 32'h20);
      wait_idle(100, 0);
      chk("t2_drained", 32'(exp_q.size()), 0);

      // Zero-length windows: rowCount=0, then rowLen=0
      for (int k = 0; k < 2; k++) begin
         rd_cnt  = 0;
         pop_cnt = 0;
         if (k == 0) start_win(32'h40, 16'd3, 16'd0, 32'd4);
         else        start_win(32'h40, 16'd0, 16'd3, 32'd4);
         chk("zl_c1_busy", 32'(busy), 1);
         chk("zl_c1_done", 32'(done), 0);
         tick();
         chk("zl_c2_busy", 32'(busy), 0);
         chk("zl_c2_done", 32'(done), 1);
         tick();
         chk("zl_reads",   32'(rd_cnt),  0);
         chk("zl_outputs", 32'(pop_cnt), 0);
         chk("zl_valid",   32'(outValid), 0);
      end

      // Backpressure: 1x10 with outReady held low, then random release
      outReady = 1'b0;
      rd_cnt   = 0;
      start_win(32'h200, 16'd10, 16'd1, 32'd0);
      repeat (7) tick();
      chk("bp_reads",    32'(rd_cnt),   4);
      chk("bp_memREn",   32'(memREn),   0);
      chk("bp_memAddr",  memAddr,       32'h204);
      chk("bp_outValid", 32'(outValid), 1);
      wait_idle(400, 1);
      chk("bp_drained",   32'(exp_q.size()), 0);
      chk("bp_reads_all", 32'(rd_cnt),       10);

      // Random windows under random backpressure
      for (int i = 0; i < 8; i++) begin
         l = 16'($urandom_range(1, 6));
         c = 16'($urandom_range(1, 4));
         rd_cnt = 0;
         start_win($urandom, l, c, $urandom);
         wait_idle(600, 1);
         chk("rnd_drained", 32'(exp_q.size()), 0);
         chk("rnd_reads",   32'(rd_cnt),       32'(l) * 32'(c));
      end

      // Start pulsed in cycle 3 of a 1x8 window is ignored
      rd_cnt  = 0;
      pop_cnt = 0;
      start_win(32'h300, 16'd8, 16'd1, 32'd0);
      tick();
      tick();
      baseAddr = 32'h999;
      rowLen   = 16'd3;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      wait_idle(100, 0);
      chk("ign_reads",   32'(rd_cnt),  8);
      chk("ign_outputs", 32'(pop_cnt), 8);
      chk("ign_done",    32'(done),    1);

      // Start accepted in the done cycle
      start_win(32'h380, 16'd2, 16'd1, 32'd0);
      chk("dc_memREn",  32'(memREn), 1);
      chk("dc_memAddr", memAddr,     32'h380);
      wait_idle(100, 0);
      chk("dc_drained", 32'(exp_q.size()), 0);

      // Asynchronous reset mid-window with FIFO occupied
      outReady = 1'b0;
      start_win(32'h400, 16'd8, 16'd1, 32'd0);
      tick();
      tick();
      tick();
      chk("mr_pre_valid", 32'(outValid), 1);
      exp_q.delete();
      #2 rst_n = 1'b0;
      #1;
      chk("mr_busy",     32'(busy),     0);
      chk("mr_memREn",   32'(memREn),   0);
      chk("mr_memAddr",  memAddr,       0);
      chk("mr_outValid", 32'(outValid), 0);
      chk("mr_outData",  32'(outData),  0);
      chk("mr_flags",    {30'd0, outRowEnd, outLast}, 0);
      tick();
      rst_n    = 1'b1;
      outReady = 1'b1;
      tick();
      pop_cnt = 0;
      start_win(32'h500, 16'd2, 16'd1, 32'd0);
      wait_idle(100, 0);
      tick();
      chk("mr_outputs", 32'(pop_cnt),      2);
      chk("mr_drained", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
